// File: rtl/mux_stream_n.sv
// N-way valid/ready stream multiplexer with fixed-select or round-robin grant and a
// registered output stage. Define MUX_STREAM_CNT_EN to build the output-beat counter.
module mux_stream_n #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic [15:0]               xfer_count
);

    logic [WIDTH-1:0] ch_data [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             grant_vld;
    logic [SEL_W-1:0] grant;
    logic             in_xfer;
    logic             out_xfer;

    assign load     = ~out_valid_q | out_ready;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        logic [SEL_W-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        if (!mode) begin
            if (32'(sel) < CHANNELS) begin
                grant     = sel;
                grant_vld = 1'b1;
            end
        end else begin
            // Scan from farthest to nearest so the channel closest to rr_ptr wins.
            for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
                idx = SEL_W'((32'(rr_ptr_q) + 32'(k)) % CHANNELS);
                if (in_valid[idx]) begin
                    grant     = idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign in_ready = (load && grant_vld && !rst) ? (CHANNELS'(1) << grant) : '0;
    assign in_xfer  = load & grant_vld & in_valid[grant];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (out_xfer) begin
            out_valid_d = 1'b0;
        end
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[grant];
            out_chan_d  = grant;
            if (mode) begin
                rr_ptr_d = SEL_W'((32'(grant) + 32'd1) % CHANNELS);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef MUX_STREAM_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`else
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_mux_stream_n.sv
// Scoreboard bench for mux_stream_n: stimulus pushes expected beats, a negedge monitor pops them.
module tb_mux_stream_n;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  chan;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic [15:0] xfer_count;

    // Non-power-of-two instance to reach sel >= CHANNELS.
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [23:0] in_data3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic [15:0] xfer_count3;

    int    total = 0;
    int    bad   = 0;
    bit    sb_en = 1'b1;
    beat_t sb_q[$];

    always #5 clk = ~clk;

    mux_stream_n #(.WIDTH(16), .CHANNELS(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .xfer_count (xfer_count)
    );

    mux_stream_n #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .mode       (1'b0),
        .sel        (sel3),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .in_data    (in_data3),
        .out_valid  (out_valid3),
        .out_ready  (1'b1),
        .out_data   (out_data3),
        .out_chan   (out_chan3),
        .xfer_count (xfer_count3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    always @(negedge clk) begin
        if (!rst && sb_en && out_valid && out_ready) begin
            beat_t b;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got data=%h chan=%0d, want no beat", out_data, out_chan);
            end else begin
                b = sb_q.pop_front();
                if (out_data !== b.data || out_chan !== b.chan) begin
                    bad++;
                    $display("FAIL sb_beat: got data=%h chan=%0d, want data=%h chan=%0d",
                             out_data, out_chan, b.data, b.chan);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b0;
        in_data   = '0;
        out_ready = 1'b0;
        sel3      = 2'd0;
        in_valid3 = 3'b0;
        in_data3  = 24'h030201;

        #2;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        #11;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'h0);
        check("rst_xfer_count", 32'(xfer_count), 32'h0);

        // Async reset while a beat is pending.
        sel      = 2'd1;
        in_valid = 4'b0010;
        set_data(16'h0000, 16'h1111, 16'h0000, 16'h0000);
        step();
        check("pend_out_valid", 32'(out_valid), 32'h1);
        check("pend_out_data", 32'(out_data), 32'h1111);
        #3;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_out_data", 32'(out_data), 32'h0);
        check("async_in_ready", 32'(in_ready), 32'h0);
        #2;
        rst = 1'b0;

        // Fixed select.
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data(16'hA000, 16'hA001, 16'hBEEF, 16'hA003);
        #1;
        check("fix_in_ready", 32'(in_ready), 32'h4);
        sb_q.push_back('{data: 16'hBEEF, chan: 2'd2});
        step();
        in_valid = 4'b0000;
        check("fix_out_valid", 32'(out_valid), 32'h1);

        sel3      = 2'd3;
        in_valid3 = 3'b111;
        #1;
        check("sel_oob_in_ready", 32'(in_ready3), 32'h0);
        sel3 = 2'd2;
        #1;
        check("sel3_in_ready", 32'(in_ready3), 32'h4);
        in_valid3 = 3'b000;
        step();

        // Back-pressure.
        sel       = 2'd1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        set_data(16'hA000, 16'hC001, 16'hA002, 16'hA003);
        sb_q.push_back('{data: 16'hC001, chan: 2'd1});
        step();
        set_data(16'hA000, 16'hC002, 16'hA002, 16'hA003);
        sb_q.push_back('{data: 16'hC002, chan: 2'd1});
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_out_data", 32'(out_data), 32'hC001);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'h2);
        step();
        check("nobubble_valid", 32'(out_valid), 32'h1);
        check("nobubble_data", 32'(out_data), 32'hC002);
        in_valid = 4'b0000;
        step();

        // Round-robin fairness; rr_ptr must still be 0 after mode-0 traffic.
        mode     = 1'b1;
        in_valid = 4'b1111;
        set_data(16'd0, 16'd1, 16'd2, 16'd3);
        #1;
        check("rr_start_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{data: 16'(i % 4), chan: 2'(i % 4)});
        end
        repeat (6) step();
        in_valid = 4'b0000;
        step();

        // Skip and wrap: rr_ptr is 2 here; ch2 moves it to 3.
        in_valid = 4'b0100;
        #1;
        check("rr_ch2_in_ready", 32'(in_ready), 32'h4);
        sb_q.push_back('{data: 16'd2, chan: 2'd2});
        step();
        in_valid = 4'b0010;
        #1;
        check("rr_wrap_in_ready", 32'(in_ready), 32'h2);
        sb_q.push_back('{data: 16'd1, chan: 2'd1});
        step();
        in_valid = 4'b0001;
        #1;
        check("rr_skip_in_ready", 32'(in_ready), 32'h1);
        sb_q.push_back('{data: 16'd0, chan: 2'd0});
        step();
        in_valid = 4'b0000;
        #1;
        check("rr_none_in_ready", 32'(in_ready), 32'h0);
        step();
        step();

`ifdef MUX_STREAM_CNT_EN
        check("cnt_after_traffic", 32'(xfer_count), 32'd12);
        sb_en    = 1'b0;
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0001;
        step();
        repeat (65535 - 12) step();
        check("cnt_ffff", 32'(xfer_count), 32'hFFFF);
        step();
        check("cnt_wrap", 32'(xfer_count), 32'h0);
        in_valid = 4'b0000;
        step();
        step();
        sb_en = 1'b1;
`else
        check("cnt_tied_zero", 32'(xfer_count), 32'h0);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
